pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with valid/ready handshaking, a two-entry skid buffer, flush-to-bubble and a saturating stall counter. It generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block that can sit between any two processor stages. It lets the core stall and flush per stage without combinational ready paths crossing stage boundaries.

---
 rtl/pipe_stage_skid_if.sv | 24 ++
 rtl/pipe_stage_skid.sv | 86 ++++++++
 tb/tb_pipe_stage_skid.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, flush-to-bubble and a
// saturating stall counter; in_ready depends only on registered state.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_stage_skid_if.slave bus,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              release_hs;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == SKID);
  assign accept     = bus.in_valid && !skid_valid;
  assign release_hs = main_valid && bus.out_ready;

  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  // Bubble: control is gated so an empty stage never issues side effects downstream.
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
    end else begin
      if (main_valid && !bus.out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_data <= bus.in_data;
              main_ctrl <= bus.in_ctrl;
              state     <= FULL;
            end
          end
          FULL: begin
            if (release_hs && accept) begin
              main_data <= bus.in_data;
              main_ctrl <= bus.in_ctrl;
            end else if (release_hs) begin
              state <= EMPTY;
            end else if (accept) begin
              skid_data <= bus.in_data;
              skid_ctrl <= bus.in_ctrl;
              state     <= SKID;
            end
          end
          SKID: begin
            if (release_hs) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              state     <= FULL;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid with a queue-based reference model.
module tb_pipe_stage_skid;
  localparam int DATA_W  = 96;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  entry_t            held[$];
  int                m_cnt = 0;
  logic [DATA_W-1:0] last_data = '0;
  bit                armed = 1'b0;
  int                total = 0;
  int                bad = 0;

  // Reference model: the stage is a FIFO of at most two entries.
  always @(posedge clk) begin : model
    bit room;
    armed = 1'b1;
    if (!resetn) begin
      held.delete();
      m_cnt     = 0;
      last_data = '0;
    end else begin
      room = (held.size() < 2);
      if (held.size() != 0 && !bus.out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (held.size() != 0 && bus.out_ready) void'(held.pop_front());
      if (bus.in_valid && room) held.push_back('{bus.in_data, bus.in_ctrl});
      if (flush) held.delete();
      if (held.size() != 0) last_data = held[0].data;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every registered output against the model between edges.
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 128'(bus.out_valid), 128'(held.size() != 0));
      chk("in_ready",  128'(bus.in_ready),  128'(held.size() < 2));
      chk("stall_cnt", 128'(stall_cnt),     128'(m_cnt));
      if (held.size() != 0) begin
        chk("out_data", 128'(bus.out_data), 128'(held[0].data));
        chk("out_ctrl", 128'(bus.out_ctrl), 128'(held[0].ctrl));
      end else begin
        chk("out_data_hold", 128'(bus.out_data), 128'(last_data));
        chk("out_ctrl_bubble", 128'(bus.out_ctrl), 128'(0));
      end
    end
  end

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl, input logic rn);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
    resetn        = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;

    // Reset held with traffic offered
    step(1'b1, 96'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 96'h0, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Streaming
    for (int i = 0; i < 5; i++)
      step(1'b1, 96'(32'hA0 + i), 8'(i + 1), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Skid: X into main, Y into skid, Z refused, then drain
    step(1'b1, 96'hB0, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hB1, 8'h12, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hB2, 8'h13, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hB2, 8'h13, 1'b0, 1'b0, 1'b1);
    step(1'b0, 96'hB2, 8'h13, 1'b1, 1'b0, 1'b1);
    step(1'b1, 96'hB2, 8'h13, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Flush from SKID with an input offered
    step(1'b1, 96'hC0, 8'h21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hC1, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hC2, 8'h23, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Stall counter saturation, survives flush, cleared by reset
    step(1'b1, 96'hD0, 8'h31, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Reset while in SKID
    step(1'b1, 96'hE0, 8'h41, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hE1, 8'h42, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           {$urandom, $urandom, $urandom},
           8'($urandom),
           1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 199) != 0));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
